ballot_tally: RTL and testbench
===============================

# ballot_tally

Sequential vote collector that feeds the election decision logic. Accepts individual popular ballots one per clock, accumulates per-candidate totals VA..VD, then captures the four jury votes J1..J4, and presents the frozen result set with a `done` flag. It is the producer side of the VA..VD / J1..J4 interface consumed by the winner-decision block.

## Interface

Parameters:
- `CNT_W`, 6: width of each candidate total.
- `NUM_JUDGES`, 4: number of jury votes collected (fixed at 4 for the current decision block).

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  opens a new election; clears all totals and judge votes.
- `ballot_valid`  in  1  a popular ballot is presented this cycle.
- `ballot_cand`  in  2  candidate code of the ballot: 00=A, 01=B, 10=C, 11=D.
- `ballot_ready`  out  1  high only in VOTING; ballot accepted when valid && ready.
- `close`  in  1  ends popular voting.
- `judge_valid`  in  1  a jury vote is presented this cycle.
- `judge_idx`  in  2  judge number: 00=J1 … 11=J4.
- `judge_vote`  in  2  candidate code voted by that judge.
- `VA`, `VB`, `VC`, `VD`  out  CNT_W  registered candidate totals.
- `J1`, `J2`, `J3`, `J4`  out  2  registered jury votes.
- `done`  out  1  high in DONE; outputs stable and valid for the decision block.
- `sat`  out  1  sticky: some total reached 63 and a further ballot for it was dropped.

## Operation

- States: IDLE, VOTING, JURY, DONE.
- IDLE: `ballot_ready`=0; `start` -> VOTING.
- VOTING: `ballot_ready`=1. Accepted ballot increments the matching total by 1; total at 2^CNT_W-1 holds and sets `sat`. `close` -> JURY.
- JURY: `judge_valid` writes `judge_vote` to judge slot `judge_idx` and sets its received bit. A vote for an already-received slot is ignored (first vote stands). When all 4 received bits are set -> DONE.
- DONE: `done`=1; all outputs frozen. `start` -> VOTING.
- `start` in VOTING/JURY/DONE: clears totals, judge slots, received bits, `sat`; goes to VOTING. `start` in IDLE does the same.
- Ballot and `close` in the same cycle: ballot counted, then JURY.
- `start` and `close` in the same cycle: `start` wins.
- `judge_valid` outside JURY and `ballot_valid` outside VOTING: ignored, no effect.
- Arithmetic: unsigned, CNT_W bits, saturating, never wraps.

## Timing

- Reset values: state IDLE, VA..VD=0, J1..J4=00, `done`=0, `ballot_ready`=0, `sat`=0.
- Totals update on the clock edge accepting the ballot; visible the following cycle. Throughput one ballot per cycle.
- `ballot_ready` drops the cycle after `close` is sampled.
- `done` rises the cycle after the fourth distinct judge vote is sampled.
- Reset mid-operation: all state lost, back to reset values next cycle.

## Configuration

- `BALLOT_TALLY_JURY_EN` defined: JURY state present as above.
- Not defined: no JURY state; `close` goes directly VOTING -> DONE; `judge_*` inputs ignored; J1..J4 tied to 00; `done` rises the cycle after `close`.

## Structure

- Package `tally_pkg`: state enum (IDLE/VOTING/JURY/DONE), candidate codes CAND_A..CAND_D, default CNT_W, NUM_JUDGES.
- Sub-module `tally_counter`: CNT_W-bit synchronous-clear, enable, saturating counter with saturation-hit output; four instances, one per candidate.

## Test plan

- Reset, `start`, 17 ballots A, 15 B, 15 C, 53 D, `close`, judges 01,01,10,00 -> VA=010001, VB=001111, VC=001111, VD=110101, J1=01, J2=01, J3=10, J4=00, `done`=1, `sat`=0.
- 70 consecutive ballots for B -> VB=63, `sat`=1, other totals 0.
- Ballot for C in the same cycle as `close` -> VC increments by 1; next ballot ignored, `ballot_ready`=0.
- In JURY, J2 voted 11 then 00 -> J2=11; `done` stays 0 until J1, J3, J4 also arrive.
- `rst` asserted mid-VOTING with VA=5 -> next cycle all outputs at reset values, state IDLE.
- Macro undefined: `close` -> `done`=1 next cycle, J1..J4=00 despite `judge_valid` pulses.

Source files
------------

// File: rtl/tally_pkg.sv
// Shared types and constants for the ballot tally block: the controller state
// encoding, candidate codes and default sizes.
package tally_pkg;

  localparam int DEF_CNT_W      = 6;
  localparam int DEF_NUM_JUDGES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTING = 2'd1,
    JURY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] CAND_A = 2'b00;
  localparam logic [1:0] CAND_B = 2'b01;
  localparam logic [1:0] CAND_C = 2'b10;
  localparam logic [1:0] CAND_D = 2'b11;

endpackage

// File: rtl/ballot_tally_if.sv
// Ballot/jury input bus and the VA..VD / J1..J4 result bus of ballot_tally.
// master = stimulus side driving the votes, slave = the tally block.
interface ballot_tally_if
  import tally_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic             ballot_valid;
  logic [1:0]       ballot_cand;
  logic             ballot_ready;
  logic             close;
  logic             judge_valid;
  logic [1:0]       judge_idx;
  logic [1:0]       judge_vote;
  logic [CNT_W-1:0] VA, VB, VC, VD;
  logic [1:0]       J1, J2, J3, J4;
  logic             done;
  logic             sat;

  modport master (
    output start, ballot_valid, ballot_cand, close,
    output judge_valid, judge_idx, judge_vote,
    input  ballot_ready, VA, VB, VC, VD, J1, J2, J3, J4, done, sat
  );

  modport slave (
    input  start, ballot_valid, ballot_cand, close,
    input  judge_valid, judge_idx, judge_vote,
    output ballot_ready, VA, VB, VC, VD, J1, J2, J3, J4, done, sat
  );
endinterface

// File: rtl/tally_counter.sv
// Saturating per-candidate counter with synchronous clear. sat_hit flags a
// count request that arrived while the counter was already at its maximum.
module tally_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             sat_hit
);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  assign sat_hit = en && (count == MAX);

  // Count up on enable, holding at MAX instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/ballot_tally.sv
// Sequential vote collector: counts popular ballots per candidate, then
// gathers jury votes, then freezes the results with done.
// Optional feature macro: BALLOT_TALLY_JURY_EN (defined = JURY phase present;
// undefined = close goes straight to DONE and J1..J4 read 00).
module ballot_tally
  import tally_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int NUM_JUDGES = DEF_NUM_JUDGES
) (
  input  logic              clk,
  input  logic              rst,
  ballot_tally_if.slave     bus
);
  state_t           state, state_next;
  logic             accept;
  logic             all_in;
  logic             sat_flag;
  logic [CNT_W-1:0] total [4];
  logic [3:0]       hit;
  logic [1:0]       judge [NUM_JUDGES];

  // A start in the same cycle discards the ballot, since it clears anyway.
  assign accept = bus.ballot_valid && (state == VOTING) && !bus.start;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      tally_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.start),
        .en      (accept && (bus.ballot_cand == 2'(gi))),
        .count   (total[gi]),
        .sat_hit (hit[gi])
      );
    end
  endgenerate

`ifdef BALLOT_TALLY_JURY_EN
  localparam state_t CLOSE_TO = JURY;

  logic [NUM_JUDGES-1:0] rcvd, rcvd_next;
  logic                  jury_take;

  // First vote per slot stands; repeats for a received slot are dropped.
  assign jury_take = bus.judge_valid && (state == JURY) && !bus.start
                     && !rcvd[bus.judge_idx];

  // Received-bit update for this cycle's jury vote.
  always_comb begin
    rcvd_next = rcvd;
    if (jury_take) rcvd_next[bus.judge_idx] = 1'b1;
  end

  assign all_in = &rcvd_next;

  // Jury slots and received bits, cleared by reset or a new election.
  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      rcvd <= '0;
      for (int i = 0; i < NUM_JUDGES; i++) judge[i] <= 2'b00;
    end else begin
      rcvd <= rcvd_next;
      if (jury_take) judge[bus.judge_idx] <= bus.judge_vote;
    end
  end
`else
  localparam state_t CLOSE_TO = DONE;

  // Jury inputs have no function in this build.
  logic unused_judge;
  assign unused_judge = ^{bus.judge_valid, bus.judge_idx, bus.judge_vote};
  assign all_in = 1'b0;

  always_comb begin
    for (int i = 0; i < NUM_JUDGES; i++) judge[i] = 2'b00;
  end
`endif

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start from any state reopens voting and wins over close.
  always_comb begin
    state_next = state;
    if (bus.start) begin
      state_next = VOTING;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        VOTING:  if (bus.close) state_next = CLOSE_TO;
        JURY:    if (all_in) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Sticky saturation flag: set when a ballot is lost at full scale.
  always_ff @(posedge clk) begin
    if (rst || bus.start) sat_flag <= 1'b0;
    else if (|hit)        sat_flag <= 1'b1;
  end

  assign bus.ballot_ready = (state == VOTING);
  assign bus.done         = (state == DONE);
  assign bus.sat          = sat_flag;
  assign bus.VA           = total[0];
  assign bus.VB           = total[1];
  assign bus.VC           = total[2];
  assign bus.VD           = total[3];
  assign bus.J1           = judge[0];
  assign bus.J2           = judge[1];
  assign bus.J3           = judge[2];
  assign bus.J4           = judge[3];
endmodule

// File: tb/tb_ballot_tally.sv
// Self-checking bench for ballot_tally: a table of single-cycle vectors plus
// hand-written sequences for counting, saturation, jury and reset.
module tb_ballot_tally;
  import tally_pkg::*;

`ifdef BALLOT_TALLY_JURY_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ballot_tally_if #(.CNT_W(6)) bus ();

  ballot_tally #(.CNT_W(6), .NUM_JUDGES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       s;
    logic       bv;
    logic [1:0] c;
    logic       cl;
    logic       jv;
    logic [1:0] ji;
    logic [1:0] jvt;
    logic [5:0] va, vb, vc, vd;
    logic       rdy, dn, st;
  } vec_t;

  vec_t tab[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.ballot_valid = 0; bus.ballot_cand = 2'b00; bus.close = 0;
    bus.judge_valid = 0; bus.judge_idx = 2'b00; bus.judge_vote = 2'b00;
  endtask

  task automatic ballots(input int n, input logic [1:0] c);
    bus.ballot_valid = 1; bus.ballot_cand = c;
    repeat (n) tick();
    bus.ballot_valid = 0;
    $display("ballots: %0d for cand %0d -> VA=%0d VB=%0d VC=%0d VD=%0d sat=%0b",
             n, c, bus.VA, bus.VB, bus.VC, bus.VD, bus.sat);
  endtask

  task automatic judge(input logic [1:0] idx, input logic [1:0] vote);
    bus.judge_valid = 1; bus.judge_idx = idx; bus.judge_vote = vote;
    tick();
    bus.judge_valid = 0;
    $display("judge: J%0d votes %0d -> done=%0b", idx + 1, vote, bus.done);
  endtask

  task automatic pulse_start();
    bus.start = 1; tick(); bus.start = 0;
    $display("start -> ready=%0b", bus.ballot_ready);
  endtask

  task automatic pulse_close();
    bus.close = 1; tick(); bus.close = 0;
    $display("close -> ready=%0b done=%0b", bus.ballot_ready, bus.done);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_VA"}, 32'(bus.VA), 0);
    chk({tag, "_VB"}, 32'(bus.VB), 0);
    chk({tag, "_VC"}, 32'(bus.VC), 0);
    chk({tag, "_VD"}, 32'(bus.VD), 0);
    chk({tag, "_J"}, 32'({bus.J1, bus.J2, bus.J3, bus.J4}), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_ready"}, 32'(bus.ballot_ready), 0);
    chk({tag, "_sat"}, 32'(bus.sat), 0);
  endtask

  initial begin
    // s bv c cl jv ji jvt | VA VB VC VD rdy done sat
    tab[0]  = '{0, 1, 2'd0, 0, 0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 0, 0, 0};    // ballot in IDLE ignored
    tab[1]  = '{1, 0, 2'd0, 0, 0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1, 0, 0};    // start
    tab[2]  = '{0, 1, 2'd0, 0, 0, 2'd0, 2'd0, 6'd1, 6'd0, 6'd0, 6'd0, 1, 0, 0};    // A
    tab[3]  = '{0, 1, 2'd1, 0, 1, 2'd0, 2'd3, 6'd1, 6'd1, 6'd0, 6'd0, 1, 0, 0};    // B, judge ignored
    tab[4]  = '{1, 1, 2'd2, 0, 0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1, 0, 0};    // C with start: cleared
    tab[5]  = '{0, 1, 2'd3, 0, 0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd1, 1, 0, 0};    // D
    tab[6]  = '{0, 1, 2'd2, 1, 0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd1, 6'd1, 0, !JEN, 0}; // C with close: counted
    tab[7]  = '{0, 1, 2'd2, 0, 0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd1, 6'd1, 0, !JEN, 0}; // C after close ignored
    tab[8]  = '{1, 0, 2'd0, 0, 0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1, 0, 0};    // start reopens
    tab[9]  = '{0, 1, 2'd0, 0, 0, 2'd0, 2'd0, 6'd1, 6'd0, 6'd0, 6'd0, 1, 0, 0};    // A
    tab[10] = '{1, 0, 2'd0, 1, 0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1, 0, 0};    // start beats close
    tab[11] = '{0, 0, 2'd0, 1, 0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 0, !JEN, 0}; // close

    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check_reset("por");

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 12; i++) begin
      bus.start = tab[i].s; bus.ballot_valid = tab[i].bv; bus.ballot_cand = tab[i].c;
      bus.close = tab[i].cl; bus.judge_valid = tab[i].jv; bus.judge_idx = tab[i].ji;
      bus.judge_vote = tab[i].jvt;
      tick();
      idle_inputs();
      $display("vec %0d: VA=%0d VB=%0d VC=%0d VD=%0d ready=%0b done=%0b sat=%0b",
               i, bus.VA, bus.VB, bus.VC, bus.VD, bus.ballot_ready, bus.done, bus.sat);
      chk($sformatf("vec%0d_VA", i), 32'(bus.VA), 32'(tab[i].va));
      chk($sformatf("vec%0d_VB", i), 32'(bus.VB), 32'(tab[i].vb));
      chk($sformatf("vec%0d_VC", i), 32'(bus.VC), 32'(tab[i].vc));
      chk($sformatf("vec%0d_VD", i), 32'(bus.VD), 32'(tab[i].vd));
      chk($sformatf("vec%0d_ready", i), 32'(bus.ballot_ready), 32'(tab[i].rdy));
      chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(tab[i].dn));
      chk($sformatf("vec%0d_sat", i), 32'(bus.sat), 32'(tab[i].st));
    end

    // Full election: 17 A, 15 B, 15 C, 53 D.
    pulse_start();
    ballots(17, CAND_A);
    ballots(15, CAND_B);
    ballots(15, CAND_C);
    ballots(53, CAND_D);
    pulse_close();
    chk("elec_ready_after_close", 32'(bus.ballot_ready), 0);
    chk("elec_done_after_close", 32'(bus.done), 32'(!JEN));
    judge(2'd0, 2'b01);
    judge(2'd1, 2'b01);
    judge(2'd2, 2'b10);
    chk("elec_done_3_judges", 32'(bus.done), 32'(!JEN));
    judge(2'd3, 2'b00);
    chk("elec_done", 32'(bus.done), 1);
    chk("elec_VA", 32'(bus.VA), 17);
    chk("elec_VB", 32'(bus.VB), 15);
    chk("elec_VC", 32'(bus.VC), 15);
    chk("elec_VD", 32'(bus.VD), 53);
    chk("elec_J1", 32'(bus.J1), JEN ? 1 : 0);
    chk("elec_J2", 32'(bus.J2), JEN ? 1 : 0);
    chk("elec_J3", 32'(bus.J3), JEN ? 2 : 0);
    chk("elec_J4", 32'(bus.J4), 0);
    chk("elec_sat", 32'(bus.sat), 0);
    // Outputs frozen in DONE.
    ballots(3, CAND_A);
    judge(2'd0, 2'b11);
    chk("done_frozen_VA", 32'(bus.VA), 17);
    chk("done_frozen_J1", 32'(bus.J1), JEN ? 1 : 0);
    chk("done_frozen_done", 32'(bus.done), 1);

    // Saturation: 70 ballots for B, boundary at 63.
    pulse_start();
    chk("restart_done", 32'(bus.done), 0);
    chk("restart_VA", 32'(bus.VA), 0);
    ballots(63, CAND_B);
    chk("sat63_VB", 32'(bus.VB), 63);
    chk("sat63_sat", 32'(bus.sat), 0);
    ballots(1, CAND_B);
    chk("sat64_VB", 32'(bus.VB), 63);
    chk("sat64_sat", 32'(bus.sat), 1);
    ballots(6, CAND_B);
    chk("sat70_VB", 32'(bus.VB), 63);
    chk("sat70_sat", 32'(bus.sat), 1);
    chk("sat70_others", 32'({bus.VA, bus.VC, bus.VD}), 0);
    pulse_start();
    chk("sat_cleared", 32'(bus.sat), 0);
    chk("sat_VB_cleared", 32'(bus.VB), 0);

    // Jury: repeat vote ignored, done waits for all four slots.
    bus.judge_valid = 1; bus.judge_idx = 2'd0; bus.judge_vote = 2'b11;
    tick();
    idle_inputs();
    pulse_close();
    judge(2'd1, 2'b11);
    judge(2'd1, 2'b00);
    chk("jury_J2_first_stands", 32'(bus.J2), JEN ? 3 : 0);
    chk("jury_done_one", 32'(bus.done), 32'(!JEN));
    judge(2'd0, 2'b10);
    judge(2'd2, 2'b01);
    chk("jury_done_three", 32'(bus.done), 32'(!JEN));
    judge(2'd3, 2'b11);
    chk("jury_done_four", 32'(bus.done), 1);
    chk("jury_J1", 32'(bus.J1), JEN ? 2 : 0);
    chk("jury_J2", 32'(bus.J2), JEN ? 3 : 0);
    chk("jury_J3", 32'(bus.J3), JEN ? 1 : 0);
    chk("jury_J4", 32'(bus.J4), JEN ? 3 : 0);

    // Reset mid-voting.
    pulse_start();
    ballots(5, CAND_A);
    chk("pre_rst_VA", 32'(bus.VA), 5);
    rst = 1;
    tick();
    rst = 0;
    $display("reset pulse -> VA=%0d ready=%0b", bus.VA, bus.ballot_ready);
    check_reset("midrst");
    ballots(1, CAND_A);
    chk("idle_after_rst_VA", 32'(bus.VA), 0);
    chk("idle_after_rst_ready", 32'(bus.ballot_ready), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
